// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : iterative 32-cycle multiply/divide with HI/LO registers
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [5:0]         count;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               is_signed;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ok;
  logic [WIDTH-1:0]   quot;

  assign is_signed = ~op[0];
  assign sign_a    = is_signed & operand_a[WIDTH-1];
  assign sign_b    = is_signed & operand_b[WIDTH-1];
  assign mag_a     = sign_a ? -operand_a : operand_a;
  assign mag_b     = sign_b ? -operand_b : operand_b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

  // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;
  assign quot      = acc[WIDTH-1:0];

  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count == 6'(WIDTH-1)) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      // DONE lasts two cycles; the second one carries the done pulse
      DONE:    if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == DONE) && !done;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (operand_b == '0);
            count    <= '0;
            rem      <= '0;
            if (op[1]) begin
              opnd <= mag_b;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
          end else begin
            if (hi_we) hi <= hi_wdata;
            if (lo_we) lo <= lo_wdata;
          end
        end
        CALC: begin
          count <= count + 6'd1;
          if (is_div) begin
            rem <= div_ok ? div_sub : div_shift[WIDTH-1:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          if (is_div) begin
            // a zero divisor leaves an all-ones quotient regardless of sign
            lo <= (neg_res && !div_zero) ? -quot : quot;
            hi <= neg_rem ? -rem : rem;
          end else begin
            {hi, lo} <= neg_res ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit : randomized and directed checks against an arithmetic model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam int NTR = 37;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic        busy_tr [NTR];
  logic        done_tr [NTR];
  logic [31:0] hi_tr   [NTR];
  logic [31:0] lo_tr   [NTR];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Reference results from plain integer arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sp;
    logic [63:0]        up;
    case (o)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        eh = sp[63:32];
        el = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          el = 32'hFFFFFFFF; eh = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          el = 32'h80000000; eh = 32'd0;
        end else begin
          el = $signed(a) / $signed(b);
          eh = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFFFFFF; eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Launches one op and records outputs after each edge E0..E36.
  // act 1: second start sampled at edge at_k+1; act 2: MTHI write at edge at_k+1.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int act, input int at_k);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    for (int k = 0; k < NTR; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      hi_we = 1'b0;
      busy_tr[k] = busy;
      done_tr[k] = done;
      hi_tr[k]   = hi;
      lo_tr[k]   = lo;
      if (k == at_k) begin
        if (act == 1) begin
          start = 1'b1; op = 2'($urandom_range(0, 3));
          operand_a = $urandom; operand_b = $urandom;
        end else if (act == 2) begin
          hi_we = 1'b1; hi_wdata = 32'hAAAA5555;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  v_op [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [31:0] v_a  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'd7, 32'h12345678, 32'h80000000, 32'hFFFFFFF0};
    logic [31:0] v_b  [8] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                              32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] v_hi [8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF,
                              32'd1, 32'h12345678, 32'd0, 32'hFFFFFFF0};
    logic [31:0] v_lo [8] = '{32'hFFFFFFEB, 32'h00000001, 32'd1, 32'hFFFFFFFD,
                              32'd3, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] prev_hi, prev_lo;
    int nbusy, ndone;
    for (int i = 0; i < 8; i++) begin
      prev_hi = hi; prev_lo = lo;
      do_op(v_op[i], v_a[i], v_b[i], 0, -1);
      checks++;
      if (hi_tr[33] !== v_hi[i] || lo_tr[33] !== v_lo[i]) begin
        failures++;
        $display("FAIL directed%0d_result hi=%h lo=%h expected hi=%h lo=%h",
                 i, hi_tr[33], lo_tr[33], v_hi[i], v_lo[i]);
      end
      checks++;
      if (hi_tr[32] !== prev_hi || lo_tr[32] !== prev_lo) begin
        failures++;
        $display("FAIL directed%0d_hold hi=%h lo=%h expected hi=%h lo=%h before fixup",
                 i, hi_tr[32], lo_tr[32], prev_hi, prev_lo);
      end
      nbusy = 0; ndone = 0;
      for (int k = 0; k < NTR; k++) begin
        nbusy += int'(busy_tr[k]);
        ndone += int'(done_tr[k]);
      end
      checks++;
      if (nbusy != 35 || busy_tr[34] !== 1'b1 || busy_tr[35] !== 1'b0) begin
        failures++;
        $display("FAIL directed%0d_busy cycles=%0d last=%b after=%b expected 35 1 0",
                 i, nbusy, busy_tr[34], busy_tr[35]);
      end
      checks++;
      if (ndone != 1 || done_tr[34] !== 1'b1) begin
        failures++;
        $display("FAIL directed%0d_done pulses=%0d at_e34=%b expected 1 1", i, ndone, done_tr[34]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 3) == 0) a = -a;
      model(o, a, b, eh, el);
      do_op(o, a, b, 0, -1);
      checks++;
      if (hi_tr[33] !== eh || lo_tr[33] !== el || done_tr[34] !== 1'b1) begin
        failures++;
        $display("FAIL random%0d op=%0d a=%h b=%h hi=%h lo=%h done=%b expected hi=%h lo=%h done=1",
                 i, o, a, b, hi_tr[33], lo_tr[33], done_tr[34], eh, el);
      end
    end
  endtask

  task automatic test_busy_ignored();
    logic [31:0] a, b, eh, el, prev_hi;
    a = $urandom; b = $urandom;
    model(2'b01, a, b, eh, el);
    do_op(2'b01, a, b, 1, 9);
    checks++;
    if (hi_tr[33] !== eh || lo_tr[33] !== el || done_tr[34] !== 1'b1 || busy_tr[35] !== 1'b0) begin
      failures++;
      $display("FAIL start_while_busy hi=%h lo=%h done=%b busy_after=%b expected hi=%h lo=%h 1 0",
               hi_tr[33], lo_tr[33], done_tr[34], busy_tr[35], eh, el);
    end
    a = $urandom; b = $urandom | 32'd1;
    model(2'b10, a, b, eh, el);
    prev_hi = hi;
    do_op(2'b10, a, b, 2, 15);
    checks++;
    if (hi_tr[16] !== prev_hi || hi_tr[36] !== eh || lo_tr[36] !== el) begin
      failures++;
      $display("FAIL mthi_while_busy hi_mid=%h hi_end=%h lo_end=%h expected %h %h %h",
               hi_tr[16], hi_tr[36], lo_tr[36], prev_hi, eh, el);
    end
  endtask

  task automatic test_reset_midop();
    hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h5A5A5A5A; lo_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; op = 2'b01; operand_a = $urandom; operand_b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_midop busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0) begin
      failures++;
      $display("FAIL reset_no_resume busy=%b hi=%h expected 0 0", busy, hi);
    end
    do_op(2'b11, 32'd100, 32'd7, 0, -1);
    checks++;
    if (hi_tr[33] !== 32'd2 || lo_tr[33] !== 32'd14 || done_tr[34] !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_op hi=%h lo=%h done=%b expected 2 14 1", hi_tr[33], lo_tr[33], done_tr[34]);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_hi, old_lo;
    old_hi = hi; old_lo = lo;
    hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'hDEADBEEF; lo_wdata = 32'h0BADF00D;
    #1;
    checks++;
    if (hi !== old_hi || lo !== old_lo) begin
      failures++;
      $display("FAIL mt_before_edge hi=%h lo=%h expected %h %h", hi, lo, old_hi, old_lo);
    end
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hDEADBEEF || lo !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL mt_write hi=%h lo=%h expected deadbeef 0badf00d", hi, lo);
    end
  endtask

  task automatic test_start_beats_write();
    logic [31:0] prev_hi;
    prev_hi = hi;
    hi_we = 1'b1; hi_wdata = 32'h11111111;
    do_op(2'b01, 32'd3, 32'd5, 0, -1);
    checks++;
    if (hi_tr[0] !== prev_hi) begin
      failures++;
      $display("FAIL start_drops_write hi=%h expected %h", hi_tr[0], prev_hi);
    end
    checks++;
    if (hi_tr[33] !== 32'd0 || lo_tr[33] !== 32'd15) begin
      failures++;
      $display("FAIL start_with_write_result hi=%h lo=%h expected 0 f", hi_tr[33], lo_tr[33]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_start_beats_write();
    test_random();
    test_busy_ignored();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
